// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI frame receiver.
package spi_pkg;

    localparam int unsigned WIDTH_DEF = 32;
    localparam int unsigned CNT_W_DEF = $clog2(WIDTH_DEF + 2);

    localparam logic CS_RST_VAL  = 1'b1;
    localparam logic SCK_RST_VAL = 1'b0;
    localparam logic D_RST_VAL   = 1'b0;

    typedef enum logic [1:0] {
        WAIT_IDLE = 2'd0,
        IDLE      = 2'd1,
        SHIFT     = 2'd2
    } state_e;

endpackage

// File: rtl/spi_deserializer_sync.sv
// N-stage flop synchronizer for one asynchronous input line.
module spi_sync #(
    parameter int unsigned STAGES    = 2,
    parameter logic        RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic dout
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], din};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {STAGES{RESET_VAL}};
        end else begin
            sync_q <= sync_d;
        end
    end

    assign dout = sync_q[STAGES-1];

endmodule

// File: rtl/spi_deserializer.sv
// Receives one MSB-first WIDTH-bit word per CS frame and holds it on a valid/ack register.
module spi_deserializer
    import spi_pkg::*;
#(
    parameter int unsigned WIDTH       = WIDTH_DEF,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             SPI_clk,
    input  logic             CS,
    input  logic             DataBit,
    output logic [WIDTH-1:0] Data_Out,
    output logic             valid,
    input  logic             ack,
    output logic             busy,
    output logic             frame_err,
    output logic             overrun
);

    localparam int unsigned CNT_W  = $clog2(WIDTH + 2);
    // Flops between a pin and cs_s_q; the CS view is trustworthy only after this many cycles.
    localparam int unsigned SETTLE = SYNC_STAGES + 1;

    logic cs_sync, sck_sync, d_sync;

    spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(CS_RST_VAL)) u_sync_cs (
        .clk(clk), .rst_n(rst_n), .din(CS), .dout(cs_sync)
    );
    spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(SCK_RST_VAL)) u_sync_sck (
        .clk(clk), .rst_n(rst_n), .din(SPI_clk), .dout(sck_sync)
    );
    spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(D_RST_VAL)) u_sync_d (
        .clk(clk), .rst_n(rst_n), .din(DataBit), .dout(d_sync)
    );

    state_e           state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             valid_q, valid_d;
    logic             busy_q, busy_d;
    logic             frame_err_q, frame_err_d;
    logic             overrun_q, overrun_d;
    logic             cs_s_q, cs_d1_q;
    logic             sck_s_q, sck_d1_q;
    logic             d_s_q;

    logic cs_rise_c, cs_fall_c, sck_rise_c;

    always_comb begin
        cs_rise_c  = cs_s_q & ~cs_d1_q;
        cs_fall_c  = ~cs_s_q & cs_d1_q;
        sck_rise_c = sck_s_q & ~sck_d1_q;
    end

    // Next-state and frame evaluation; a CS rise wins over a coincident SCK rise.
    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        data_d      = data_q;
        cnt_d       = cnt_q;
        valid_d     = valid_q;
        busy_d      = busy_q;
        frame_err_d = 1'b0;
        overrun_d   = 1'b0;

        if (valid_q && ack) begin
            valid_d = 1'b0;
        end

        unique case (state_q)
            WAIT_IDLE: begin
                // Bit counter doubles as the settle timer while the synchronizers flush.
                if (cnt_q != CNT_W'(SETTLE)) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end else if (cs_s_q) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            IDLE: begin
                if (cs_fall_c) begin
                    state_d = SHIFT;
                    shift_d = '0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                end
            end
            SHIFT: begin
                if (cs_rise_c) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    if (cnt_q != CNT_W'(WIDTH)) begin
                        frame_err_d = 1'b1;
                    end else if (!valid_q || ack) begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                    end else begin
                        overrun_d = 1'b1;
                    end
                end else if (sck_rise_c) begin
                    shift_d = {shift_q[WIDTH-2:0], d_s_q};
                    if (cnt_q != CNT_W'(WIDTH + 1)) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = WAIT_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= WAIT_IDLE;
            shift_q     <= '0;
            data_q      <= '0;
            cnt_q       <= '0;
            valid_q     <= 1'b0;
            busy_q      <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
            cs_s_q      <= CS_RST_VAL;
            cs_d1_q     <= CS_RST_VAL;
            sck_s_q     <= SCK_RST_VAL;
            sck_d1_q    <= SCK_RST_VAL;
            d_s_q       <= D_RST_VAL;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            data_q      <= data_d;
            cnt_q       <= cnt_d;
            valid_q     <= valid_d;
            busy_q      <= busy_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
            cs_s_q      <= cs_sync;
            cs_d1_q     <= cs_s_q;
            sck_s_q     <= sck_sync;
            sck_d1_q    <= sck_s_q;
            d_s_q       <= d_sync;
        end
    end

    assign Data_Out  = data_q;
    assign valid     = valid_q;
    assign busy      = busy_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_spi_deserializer.sv
// Directed bench for spi_deserializer: table of frames plus reset and ack-at-commit sequences.
module tb_spi_deserializer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        SPI_clk;
    logic        CS;
    logic        DataBit;
    logic        ack;
    logic [31:0] Data_Out;
    logic        valid;
    logic        busy;
    logic        frame_err;
    logic        overrun;

    spi_deserializer #(.WIDTH(32), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst_n(rst_n), .SPI_clk(SPI_clk), .CS(CS), .DataBit(DataBit),
        .Data_Out(Data_Out), .valid(valid), .ack(ack), .busy(busy),
        .frame_err(frame_err), .overrun(overrun)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int ferr_seen = 0;
    int ovr_seen = 0;
    int vrise = 0;
    logic valid_prev = 1'b0;

    always @(negedge clk) begin
        if (frame_err === 1'b1) ferr_seen <= ferr_seen + 1;
        if (overrun === 1'b1) ovr_seen <= ovr_seen + 1;
        if (valid === 1'b1 && valid_prev !== 1'b1) vrise <= vrise + 1;
        valid_prev <= valid;
    end

    typedef struct {
        logic [31:0] word;
        int          nbits;
        bit          ack_first;
        logic        exp_valid;
        logic [31:0] exp_data;
        int          exp_ferr;
        int          exp_ovr;
        int          exp_vrise;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic spi_bits(input logic [31:0] w, input int first, input int last);
        for (int i = first; i < last; i++) begin
            DataBit = (i < 32) ? w[31-i] : 1'b0;
            repeat (4) @(negedge clk);
            SPI_clk = 1'b1;
            repeat (4) @(negedge clk);
            SPI_clk = 1'b0;
        end
    endtask

    task automatic frame_start();
        @(negedge clk);
        CS = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    // Commit lands on the 4th clk rise after CS goes high; ack_commit lines ack up with it.
    task automatic frame_end(input bit ack_commit);
        repeat (4) @(negedge clk);
        CS = 1'b1;
        if (ack_commit) begin
            repeat (3) @(posedge clk);
            @(negedge clk);
            ack = 1'b1;
            @(negedge clk);
            ack = 1'b0;
        end
        repeat (8) @(negedge clk);
    endtask

    task automatic pulse_ack();
        @(negedge clk);
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
    endtask

    initial begin
        int f0, o0, v0;

        vecs[0] = '{32'h009E6C8D, 32, 1'b0, 1'b1, 32'h009E6C8D, 0, 0, 1};
        vecs[1] = '{32'h0080F0FF, 32, 1'b1, 1'b1, 32'h0080F0FF, 0, 0, 1};
        vecs[2] = '{32'h009E6C8D, 32, 1'b1, 1'b1, 32'h009E6C8D, 0, 0, 1};
        vecs[3] = '{32'h0080F0FF, 32, 1'b0, 1'b1, 32'h009E6C8D, 0, 1, 0};
        vecs[4] = '{32'hA5A50F0F, 31, 1'b0, 1'b1, 32'h009E6C8D, 1, 0, 0};
        vecs[5] = '{32'hA5A50F0F, 33, 1'b0, 1'b1, 32'h009E6C8D, 1, 0, 0};
        vecs[6] = '{32'h12345678, 32, 1'b1, 1'b1, 32'h12345678, 0, 0, 1};

        rst_n = 1'b0; CS = 1'b1; SPI_clk = 1'b0; DataBit = 1'b0; ack = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_data", Data_Out, 32'h0);
        check("rst_valid", 32'(valid), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_ferr", 32'(frame_err), 32'h0);
        check("rst_ovr", 32'(overrun), 32'h0);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);

        // ack with nothing pending must be harmless
        pulse_ack();
        check("idle_ack_valid", 32'(valid), 32'h0);

        for (int v = 0; v < 7; v++) begin
            if (vecs[v].ack_first) pulse_ack();
            f0 = ferr_seen; o0 = ovr_seen; v0 = vrise;
            frame_start();
            spi_bits(vecs[v].word, 0, vecs[v].nbits);
            frame_end(1'b0);
            check($sformatf("v%0d_valid", v), 32'(valid), 32'(vecs[v].exp_valid));
            check($sformatf("v%0d_data", v), Data_Out, vecs[v].exp_data);
            check($sformatf("v%0d_ferr", v), 32'(ferr_seen - f0), 32'(vecs[v].exp_ferr));
            check($sformatf("v%0d_ovr", v), 32'(ovr_seen - o0), 32'(vecs[v].exp_ovr));
            check($sformatf("v%0d_vrise", v), 32'(vrise - v0), 32'(vecs[v].exp_vrise));
            check($sformatf("v%0d_busy", v), 32'(busy), 32'h0);
        end

        // ack coinciding with a new commit while valid is set
        f0 = ferr_seen; o0 = ovr_seen; v0 = vrise;
        frame_start();
        spi_bits(32'hDEADBEEF, 0, 32);
        frame_end(1'b1);
        check("coinc_valid", 32'(valid), 32'h1);
        check("coinc_data", Data_Out, 32'hDEADBEEF);
        check("coinc_ovr", 32'(ovr_seen - o0), 32'h0);
        check("coinc_vrise", 32'(vrise - v0), 32'h0);

        // reset mid-frame after bit 10, remainder must be ignored silently
        frame_start();
        spi_bits(32'hA5A50F0F, 0, 10);
        check("mid_busy", 32'(busy), 32'h1);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("midrst_data", Data_Out, 32'h0);
        check("midrst_valid", 32'(valid), 32'h0);
        check("midrst_busy", 32'(busy), 32'h0);
        rst_n = 1'b1;
        f0 = ferr_seen; o0 = ovr_seen;
        spi_bits(32'hA5A50F0F, 10, 32);
        frame_end(1'b0);
        check("midrst_ferr", 32'(ferr_seen - f0), 32'h0);
        check("midrst_valid2", 32'(valid), 32'h0);
        check("midrst_data2", Data_Out, 32'h0);

        frame_start();
        spi_bits(32'hA5A50F0F, 0, 32);
        frame_end(1'b0);
        check("post_valid", 32'(valid), 32'h1);
        check("post_data", Data_Out, 32'hA5A50F0F);
        check("post_ferr", 32'(ferr_seen - f0), 32'h0);
        check("post_ovr", 32'(ovr_seen - o0), 32'h0);

        pulse_ack();
        @(negedge clk);
        check("final_ack_valid", 32'(valid), 32'h0);
        check("final_ack_data", Data_Out, 32'hA5A50F0F);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/spi_deserializer.md
Name: spi_deserializer

Overview:
- Downstream receiver for the SPI_Serializer output stream (DataBit/SPI_clk/CS), running on the system clock.
- Oversamples and synchronizes the three SPI lines, shifts in one WIDTH-bit word per CS frame (MSB first, sampled on SPI_clk rising edge, CS active-low).
- Presents the word on a valid/ack holding register and flags malformed frames and overruns.
- Used for loopback checking of the serializer and as the receive side of board-level links.

Parameters:
- WIDTH, 32, bits per frame / output word width.
- SYNC_STAGES, 2, flip-flop stages in each input synchronizer (≥2).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- SPI_clk  input  1  serial clock from serializer; asynchronous to clk.
- CS  input  1  chip select, active-low frame envelope.
- DataBit  input  1  serial data, MSB first.
- Data_Out  output  WIDTH  last accepted word.
- valid  output  1  Data_Out holds an unconsumed word.
- ack  input  1  consumer accepts word; effective only when valid=1.
- busy  output  1  frame in progress (state SHIFT).
- frame_err  output  1  one-cycle pulse: frame ended with bit count ≠ WIDTH.
- overrun  output  1  one-cycle pulse: complete frame discarded because valid still set.

Behaviour:
- Reset (async, rst_n=0): Data_Out=0, valid=0, busy=0, frame_err=0, overrun=0, shift reg=0, bit count=0, state WAIT_IDLE; CS synchronizer resets to 1, SPI_clk and DataBit synchronizers to 0.
- Inputs pass through SYNC_STAGES flops (spi_sync), then one edge-detect register; CS_s, SCK_s, D_s are the synchronized copies.
- Input constraint: SPI_clk high and low phases each ≥ SYNC_STAGES+1 clk periods; DataBit stable around SPI_clk rise for the same window.
- FSM:
  - WAIT_IDLE: stay until CS_s=1, then IDLE. Prevents capture of a frame already in progress at reset release; the remainder of that frame is ignored silently, with no frame_err.
  - IDLE: CS_s falling edge → SHIFT; clear shift reg and bit count; busy=1 from next cycle. SPI_clk edges are ignored.
  - SHIFT: each SCK_s rising edge: shift_reg <= {shift_reg[WIDTH-2:0], D_s}; bit count increments, saturating at WIDTH+1.
  - SHIFT, on CS_s rising edge → IDLE; busy=0 next cycle. Then evaluate the frame:
    - bit count ≠ WIDTH (short or long): frame_err pulses 1 cycle; Data_Out and valid unchanged.
    - bit count = WIDTH and (valid=0 or ack=1): Data_Out <= shift_reg, valid=1.
    - bit count = WIDTH and valid=1 and ack=0: overrun pulses 1 cycle; new word discarded; Data_Out retained.
- SCK_s rising and CS_s rising in the same clk cycle: the clock edge is ignored; frame is evaluated on the prior count.
- Latency: valid rises SYNC_STAGES+2 clk cycles after the CS pin rising edge.
- Handshake: valid && ack → valid=0 next cycle; Data_Out retains value. ack with valid=0 has no effect. ack coinciding with a commit → valid stays 1 with the new word.
- A CS rise then fall within the constraint window is a legal back-to-back frame.
- Reset mid-frame: immediate return to reset values; the partial word is lost.

Decomposition:
- Package spi_pkg:
  - default WIDTH
  - state encoding localparams WAIT_IDLE/IDLE/SHIFT
  - CNT_W = $clog2(WIDTH+2)
  - synchronizer reset-value constants
- Sub-module spi_sync: parameterized N-stage synchronizer (STAGES, RESET_VAL) with async active-low reset; instantiated three times.

Test Plan:
- Serializer loopback, ld with Data_Register=32'h009E6C8D → valid=1 with Data_Out=32'h009E6C8D, frame_err=0; ack → valid=0.
- Second frame 32'h0080F0FF after ack → Data_Out=32'h0080F0FF, single valid assertion, no overrun.
- Two frames 32'h009E6C8D then 32'h0080F0FF with ack held 0 → overrun pulse once; Data_Out stays 32'h009E6C8D.
- Bench-driven frame of 31 clocks then CS high → frame_err pulse; valid unchanged. Frame of 33 clocks → frame_err pulse.
- rst_n pulsed low after bit 10 of a frame → all outputs 0; remaining bits ignored with no frame_err; the next full frame 32'hA5A5_0F0F is received correctly.
- ack asserted in the same cycle a new word commits with valid=1 → valid stays 1, Data_Out = new word, overrun=0.
